mem_wb_multi: RTL



---
 rtl/wb_pkg.sv | 45 ++++
 rtl/excp_decode.sv | 72 +++++++
 rtl/mem_wb_multi.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the MEM/WB commit stage: exception bit indices,
// ECODE/ESUBCODE values and the squash FSM state type.
package wb_pkg;

  localparam int unsigned EXCP_W = 16;

  // Exception vector bit positions; bit 0 has the highest priority.
  localparam logic [3:0] EXCP_INT    = 4'd0;
  localparam logic [3:0] EXCP_ADEF   = 4'd1;
  localparam logic [3:0] EXCP_TLBR_F = 4'd2;
  localparam logic [3:0] EXCP_PIF    = 4'd3;
  localparam logic [3:0] EXCP_PPI_F  = 4'd4;
  localparam logic [3:0] EXCP_SYS    = 4'd5;
  localparam logic [3:0] EXCP_BRK    = 4'd6;
  localparam logic [3:0] EXCP_INE    = 4'd7;
  localparam logic [3:0] EXCP_IPE    = 4'd8;
  localparam logic [3:0] EXCP_ALE    = 4'd9;
  localparam logic [3:0] EXCP_ADEM   = 4'd10;
  localparam logic [3:0] EXCP_TLBR_M = 4'd11;
  localparam logic [3:0] EXCP_PME    = 4'd12;
  localparam logic [3:0] EXCP_PPI_M  = 4'd13;
  localparam logic [3:0] EXCP_PIS    = 4'd14;
  localparam logic [3:0] EXCP_PIL    = 4'd15;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ADEM = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;
  localparam logic [5:0] ECODE_IPE  = 6'h0e;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  typedef enum logic [0:0] {StIdle, StSquash} squash_state_e;

endpackage

// File: rtl/excp_decode.sv
// Combinational exception decoder: picks the highest-priority set bit and
// derives ecode, sub-code, bad virtual address and TLB report.
module excp_decode import wb_pkg::*; #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [EXCP_W-1:0] excp,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] bad_addr,
  output logic [5:0]        ecode,
  output logic [8:0]        esubcode,
  output logic              va_error,
  output logic [DATA_W-1:0] bad_va,
  output logic              tlb,
  output logic              tlbrefill,
  output logic [18:0]       vppn
);

  logic       hit;
  logic [3:0] b;

  always_comb begin
    hit       = 1'b0;
    b         = '0;
    ecode     = '0;
    esubcode  = '0;
    va_error  = 1'b0;
    bad_va    = '0;
    tlb       = 1'b0;
    tlbrefill = 1'b0;
    // Descending scan so the lowest set bit wins.
    for (int i = int'(EXCP_W) - 1; i >= 0; i--) begin
      if (excp[i]) begin
        hit = 1'b1;
        b   = 4'(i);
      end
    end
    if (hit) begin
      case (b)
        EXCP_INT:    ecode = ECODE_INT;
        EXCP_ADEF:   ecode = ECODE_ADEF;
        EXCP_TLBR_F: ecode = ECODE_TLBR;
        EXCP_PIF:    ecode = ECODE_PIF;
        EXCP_PPI_F:  ecode = ECODE_PPI;
        EXCP_SYS:    ecode = ECODE_SYS;
        EXCP_BRK:    ecode = ECODE_BRK;
        EXCP_INE:    ecode = ECODE_INE;
        EXCP_IPE:    ecode = ECODE_IPE;
        EXCP_ALE:    ecode = ECODE_ALE;
        EXCP_ADEM:   ecode = ECODE_ADEM;
        EXCP_TLBR_M: ecode = ECODE_TLBR;
        EXCP_PME:    ecode = ECODE_PME;
        EXCP_PPI_M:  ecode = ECODE_PPI;
        EXCP_PIS:    ecode = ECODE_PIS;
        default:     ecode = ECODE_PIL;
      endcase
      if (b inside {EXCP_ADEF, EXCP_TLBR_F, EXCP_PIF, EXCP_PPI_F}) begin
        va_error = 1'b1;
        bad_va   = pc;
      end else if (b >= EXCP_ALE) begin
        va_error = 1'b1;
        bad_va   = bad_addr;
      end
      if (b == EXCP_ADEF) esubcode = ESUBCODE_ADEF;
      if (b == EXCP_ADEM) esubcode = ESUBCODE_ADEM;
      tlbrefill = (b == EXCP_TLBR_F) || (b == EXCP_TLBR_M);
      tlb       = (b inside {EXCP_TLBR_F, EXCP_PIF, EXCP_PPI_F}) || (b >= EXCP_TLBR_M);
    end
  end

  assign vppn = bad_va[DATA_W-1 -: 19];

endmodule

// File: rtl/mem_wb_multi.sv
// Multi-lane MEM/WB pipeline register and exception commit point: commits lanes
// older than the oldest fault, squashes the rest, reports the fault to the CSRs.
module mem_wb_multi #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned EXCP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [LANES-1:0]         mem_valid,
  input  logic [LANES*DATA_W-1:0]  mem_pc,
  input  logic [LANES*DATA_W-1:0]  mem_instr,
  input  logic [LANES*RA_W-1:0]    mem_wd,
  input  logic [LANES-1:0]         mem_wreg,
  input  logic [LANES*DATA_W-1:0]  mem_wdata,
  input  logic [LANES-1:0]         mem_csr_we,
  input  logic [LANES*14-1:0]      mem_csr_addr,
  input  logic [LANES*DATA_W-1:0]  mem_csr_data,
  input  logic [LANES-1:0]         mem_llbit_we,
  input  logic [LANES-1:0]         mem_llbit_value,
  input  logic [LANES-1:0]         mem_is_ertn,
  input  logic [LANES*EXCP_W-1:0]  mem_excp_num,
  input  logic [LANES*DATA_W-1:0]  mem_bad_addr,
  output logic [LANES*RA_W-1:0]    wb_wd,
  output logic [LANES-1:0]         wb_wreg,
  output logic [LANES*DATA_W-1:0]  wb_wdata,
  output logic [LANES-1:0]         wb_csr_we,
  output logic [LANES*14-1:0]      wb_csr_addr,
  output logic [LANES*DATA_W-1:0]  wb_csr_data,
  output logic [LANES-1:0]         wb_llbit_we,
  output logic [LANES-1:0]         wb_llbit_value,
  output logic [LANES-1:0]         debug_commit_valid,
  output logic [LANES*DATA_W-1:0]  debug_commit_pc,
  output logic [LANES*DATA_W-1:0]  debug_commit_instr,
  output logic                     excp_flush,
  output logic                     ertn_flush,
  output logic [DATA_W-1:0]        csr_era,
  output logic [5:0]               csr_ecode,
  output logic [8:0]               csr_esubcode,
  output logic                     va_error,
  output logic [DATA_W-1:0]        bad_va,
  output logic                     excp_tlbrefill,
  output logic                     excp_tlb,
  output logic [18:0]              excp_tlb_vppn,
  output logic [31:0]              commit_cnt
);
  import wb_pkg::*;

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;

  squash_state_e state_q, state_d;
  logic squash_q;

  logic [LANES-1:0]  accept, commit;
  logic              fault_found;
  logic [LaneW-1:0]  k;
  logic [EXCP_W-1:0] sel_excp;
  logic [DATA_W-1:0] sel_pc, sel_bad_addr;
  logic              excp_taken, ertn_taken;

  logic [5:0]        dec_ecode;
  logic [8:0]        dec_esubcode;
  logic              dec_va_error, dec_tlb, dec_tlbrefill;
  logic [DATA_W-1:0] dec_bad_va;
  logic [18:0]       dec_vppn;

  logic [LANES*RA_W-1:0]   wd_q, wd_d;
  logic [LANES-1:0]        wreg_q, wreg_d, csr_we_q, csr_we_d;
  logic [LANES-1:0]        llwe_q, llwe_d, llval_q, llval_d, dv_q, dv_d;
  logic [LANES*DATA_W-1:0] wdata_q, wdata_d, csr_data_q, csr_data_d;
  logic [LANES*DATA_W-1:0] dpc_q, dpc_d, dinstr_q, dinstr_d;
  logic [LANES*14-1:0]     csr_addr_q, csr_addr_d;
  logic                    excp_flush_q, excp_flush_d, ertn_flush_q, ertn_flush_d;
  logic [DATA_W-1:0]       era_q, era_d, bad_va_q, bad_va_d;
  logic [5:0]              ecode_q, ecode_d;
  logic [8:0]              esub_q, esub_d;
  logic                    va_err_q, va_err_d, tlb_q, tlb_d, tlbr_q, tlbr_d;
  logic [18:0]             vppn_q, vppn_d;
  logic [31:0]             cnt_q, cnt_d, cnt_inc;

  assign squash_q = (state_q == StSquash);

  // Lanes at or above the oldest faulting lane are blocked from committing.
  always_comb begin
    accept      = '0;
    commit      = '0;
    fault_found = 1'b0;
    k           = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      accept[i] = !rst && !flush && !squash_q && !stall && mem_valid[i];
      if (accept[i] && !fault_found &&
          ((|mem_excp_num[i*EXCP_W +: EXCP_W]) || mem_is_ertn[i])) begin
        fault_found = 1'b1;
        k           = LaneW'(i);
      end
      commit[i] = accept[i] && !fault_found;
    end
  end

  assign sel_excp     = mem_excp_num[k*EXCP_W +: EXCP_W];
  assign sel_pc       = mem_pc[k*DATA_W +: DATA_W];
  assign sel_bad_addr = mem_bad_addr[k*DATA_W +: DATA_W];
  assign excp_taken   = fault_found && (|sel_excp);
  assign ertn_taken   = fault_found && !(|sel_excp) && mem_is_ertn[k];

  excp_decode #(
    .DATA_W(DATA_W)
  ) u_excp_decode (
    .excp      (sel_excp),
    .pc        (sel_pc),
    .bad_addr  (sel_bad_addr),
    .ecode     (dec_ecode),
    .esubcode  (dec_esubcode),
    .va_error  (dec_va_error),
    .bad_va    (dec_bad_va),
    .tlb       (dec_tlb),
    .tlbrefill (dec_tlbrefill),
    .vppn      (dec_vppn)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (excp_taken || ertn_taken) state_d = StSquash;
      StSquash: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wd_d         = wd_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    csr_we_d     = csr_we_q;
    csr_addr_d   = csr_addr_q;
    csr_data_d   = csr_data_q;
    llwe_d       = llwe_q;
    llval_d      = llval_q;
    dpc_d        = dpc_q;
    dinstr_d     = dinstr_q;
    era_d        = era_q;
    ecode_d      = ecode_q;
    esub_d       = esub_q;
    va_err_d     = va_err_q;
    bad_va_d     = bad_va_q;
    tlb_d        = tlb_q;
    tlbr_d       = tlbr_q;
    vppn_d       = vppn_q;
    dv_d         = '0;
    excp_flush_d = 1'b0;
    ertn_flush_d = 1'b0;
    cnt_inc      = '0;
    cnt_d        = cnt_q;
    if (flush || squash_q) begin
      wd_d       = '0;
      wreg_d     = '0;
      wdata_d    = '0;
      csr_we_d   = '0;
      csr_addr_d = '0;
      csr_data_d = '0;
      llwe_d     = '0;
      llval_d    = '0;
      dpc_d      = '0;
      dinstr_d   = '0;
      era_d      = '0;
      ecode_d    = '0;
      esub_d     = '0;
      va_err_d   = 1'b0;
      bad_va_d   = '0;
      tlb_d      = 1'b0;
      tlbr_d     = 1'b0;
      vppn_d     = '0;
    end else if (!stall) begin
      for (int i = 0; i < int'(LANES); i++) begin
        wd_d[i*RA_W +: RA_W]         = commit[i] ? mem_wd[i*RA_W +: RA_W] : '0;
        wdata_d[i*DATA_W +: DATA_W]  = commit[i] ? mem_wdata[i*DATA_W +: DATA_W] : '0;
        csr_addr_d[i*14 +: 14]       = commit[i] ? mem_csr_addr[i*14 +: 14] : '0;
        csr_data_d[i*DATA_W +: DATA_W] = commit[i] ? mem_csr_data[i*DATA_W +: DATA_W] : '0;
        dpc_d[i*DATA_W +: DATA_W]    = commit[i] ? mem_pc[i*DATA_W +: DATA_W] : '0;
        dinstr_d[i*DATA_W +: DATA_W] = commit[i] ? mem_instr[i*DATA_W +: DATA_W] : '0;
        wreg_d[i]   = commit[i] && mem_wreg[i];
        csr_we_d[i] = commit[i] && mem_csr_we[i];
        llwe_d[i]   = commit[i] && mem_llbit_we[i];
        llval_d[i]  = commit[i] && mem_llbit_value[i];
        cnt_inc     = cnt_inc + 32'(commit[i]);
      end
      dv_d         = commit;
      excp_flush_d = excp_taken;
      ertn_flush_d = ertn_taken;
      era_d        = fault_found ? sel_pc : '0;
      ecode_d      = excp_taken ? dec_ecode : '0;
      esub_d       = excp_taken ? dec_esubcode : '0;
      va_err_d     = excp_taken && dec_va_error;
      bad_va_d     = excp_taken ? dec_bad_va : '0;
      tlb_d        = excp_taken && dec_tlb;
      tlbr_d       = excp_taken && dec_tlbrefill;
      vppn_d       = excp_taken ? dec_vppn : '0;
      cnt_d        = cnt_q + cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wd_q         <= '0;
      wreg_q       <= '0;
      wdata_q      <= '0;
      csr_we_q     <= '0;
      csr_addr_q   <= '0;
      csr_data_q   <= '0;
      llwe_q       <= '0;
      llval_q      <= '0;
      dv_q         <= '0;
      dpc_q        <= '0;
      dinstr_q     <= '0;
      excp_flush_q <= 1'b0;
      ertn_flush_q <= 1'b0;
      era_q        <= '0;
      ecode_q      <= '0;
      esub_q       <= '0;
      va_err_q     <= 1'b0;
      bad_va_q     <= '0;
      tlb_q        <= 1'b0;
      tlbr_q       <= 1'b0;
      vppn_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
      csr_we_q     <= csr_we_d;
      csr_addr_q   <= csr_addr_d;
      csr_data_q   <= csr_data_d;
      llwe_q       <= llwe_d;
      llval_q      <= llval_d;
      dv_q         <= dv_d;
      dpc_q        <= dpc_d;
      dinstr_q     <= dinstr_d;
      excp_flush_q <= excp_flush_d;
      ertn_flush_q <= ertn_flush_d;
      era_q        <= era_d;
      ecode_q      <= ecode_d;
      esub_q       <= esub_d;
      va_err_q     <= va_err_d;
      bad_va_q     <= bad_va_d;
      tlb_q        <= tlb_d;
      tlbr_q       <= tlbr_d;
      vppn_q       <= vppn_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wb_wd              = wd_q;
  assign wb_wreg            = wreg_q;
  assign wb_wdata           = wdata_q;
  assign wb_csr_we          = csr_we_q;
  assign wb_csr_addr        = csr_addr_q;
  assign wb_csr_data        = csr_data_q;
  assign wb_llbit_we        = llwe_q;
  assign wb_llbit_value     = llval_q;
  assign debug_commit_valid = dv_q;
  assign debug_commit_pc    = dpc_q;
  assign debug_commit_instr = dinstr_q;
  assign excp_flush         = excp_flush_q;
  assign ertn_flush         = ertn_flush_q;
  assign csr_era            = era_q;
  assign csr_ecode          = ecode_q;
  assign csr_esubcode       = esub_q;
  assign va_error           = va_err_q;
  assign bad_va             = bad_va_q;
  assign excp_tlbrefill     = tlbr_q;
  assign excp_tlb           = tlb_q;
  assign excp_tlb_vppn      = vppn_q;
  assign commit_cnt         = cnt_q;

endmodule
